reverb_template_s2m_fifo_ffta: RTL and testbench
================================================

Name: reverb_template_s2m_fifo_ffta

Overview:
- Streaming-to-memory-mapped FIFO: accepts 32-bit samples on an Avalon-ST sink and buffers them.
- The Nios II reads the samples through an Avalon-MM read slave.
- It is the return path from the FFT/reverb datapath to software, the counterpart of the m2s FIFO feeding that datapath.
- Storage is an internal register/RAM array with its own pointers and occupancy counter; there is no scfifo megafunction.

Parameters:
- DATA_WIDTH, 32, word width on both sides (must be >= 18 for the status word).
- DEPTH, 64, FIFO capacity in words (power of two).
- ADDR_WIDTH, 6, log2(DEPTH) (<= 15).

Ports:
- rdclock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avalonst_sink_data  in  DATA_WIDTH  stream sample.
- avalonst_sink_valid  in  1  sample valid.
- avalonst_sink_ready  out  1  FIFO can accept a sample.
- avalonmm_read_slave_address  in  1  0 = data pop, 1 = status.
- avalonmm_read_slave_read  in  1  read strobe.
- avalonmm_read_slave_waitrequest  out  1  stall the master.
- avalonmm_read_slave_readdata  out  DATA_WIDTH  registered read data.
- avalonmm_read_slave_readdatavalid  out  1  readdata valid (fixed latency 1).
- fill_level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Clocking and reset: one clock, rdclock; reset_n is asynchronous assert, active-low.
- On reset assertion:
  - write pointer, read pointer and count clear to 0 immediately.
  - readdata clears to 0 and readdatavalid to 0.
  - fill_level reads 0.
  - sink_ready and waitrequest are forced, combinationally: ready=0, waitrequest=1.
- full = (count == DEPTH); empty = (count == 0). Both are derived from the registered count.
- Stream side:
  - sink_ready = reset_n & ~full, with no combinational path from the MM read.
  - push = valid & ready; it writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (natural wrap at ADDR_WIDTH bits).
  - valid while ready=0 is ignored; the sender holds data.
- MM side:
  - waitrequest = ~reset_n | (read & address==0 & empty).
  - Accepted read = read & ~waitrequest.
  - Address 0 accepted: pops mem[rd_ptr], increments rd_ptr modulo DEPTH; readdata <= popped word on the next edge.
  - Address 1 accepted: readdata <= status word, no pop.
    - bits[ADDR_WIDTH:0] = count
    - bit16 = empty
    - bit17 = full
    - all other bits 0.
  - readdatavalid <= accepted read, so it is high exactly one cycle after each acceptance.
  - When no read is accepted, readdatavalid=0 and readdata holds its last value.
  - Back-to-back reads on consecutive cycles are supported; throughput is 1 word/cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - fill_level = count.
- Boundaries:
  - Push into an empty FIFO: the word becomes poppable the following cycle; waitrequest on a pending address-0 read drops one cycle after the push.
  - Full FIFO with a pop in the same cycle: ready stays 0 that cycle and reasserts the next cycle.
  - Pop is impossible when empty (waitrequest holds the master) and push is impossible when full; no over/underflow is possible.
  - Reset mid-operation: all buffered data is discarded; no readdatavalid is issued for reads pending at reset.

Test Plan:
1. Reset:
   - During reset: ready=0, waitrequest=1, readdatavalid=0.
   - After release: ready=1; a status read returns 0x00010000 with readdatavalid one cycle after acceptance.
2. Ordering:
   - Push 0xA1, 0xA2, 0xA3 -> fill_level=3 and status 0x00000003.
   - Three back-to-back address-0 reads return 0xA1, 0xA2, 0xA3 on consecutive cycles, each one cycle after acceptance; then fill_level=0.
3. Full and wrap:
   - Push 64 words 0..63 -> ready drops the cycle after the 64th push; status 0x00020040.
   - One pop returns 0 and ready reasserts next cycle.
   - Push 64 -> drain returns 1..64 in order (pointer wrap).
4. Empty stall:
   - Address-0 read on an empty FIFO -> waitrequest held high for 10 cycles.
   - Push 0xDEADBEEF -> waitrequest drops the next cycle; readdata=0xDEADBEEF with readdatavalid the cycle after.
5. Concurrent push/pop:
   - At count=5, push and pop every cycle for 20 cycles -> fill_level stays 5 and popped data keeps strict FIFO order.
6. Reset mid-operation:
   - At count=10 with a read just accepted, assert reset_n=0 -> readdatavalid and fill_level go to 0 immediately.
   - After release, status reads 0x00010000 and no stale word is returned.

Source files
------------

// File: rtl/reverb_template_s2m_fifo_ffta.sv
// Streaming-to-memory-mapped FIFO: Avalon-ST samples in, Avalon-MM reads out.
// Address 0 pops one word; address 1 returns the occupancy/empty/full status word.
module reverb_template_s2m_fifo_ffta #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  rdclock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] avalonst_sink_data,
  input  logic                  avalonst_sink_valid,
  output logic                  avalonst_sink_ready,
  input  logic                  avalonmm_read_slave_address,
  input  logic                  avalonmm_read_slave_read,
  output logic                  avalonmm_read_slave_waitrequest,
  output logic [DATA_WIDTH-1:0] avalonmm_read_slave_readdata,
  output logic                  avalonmm_read_slave_readdatavalid,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic                  readdatavalid_q, readdatavalid_d;

  logic                  full, empty, push, pop, rd_accept;
  logic [DATA_WIDTH-1:0] status_word;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Ready and waitrequest depend only on reset and registered occupancy, so the
  // MM read never combinationally gates the stream side.
  assign avalonst_sink_ready             = reset_n & ~full;
  assign avalonmm_read_slave_waitrequest = ~reset_n |
      (avalonmm_read_slave_read & ~avalonmm_read_slave_address & empty);

  assign push      = avalonst_sink_valid & avalonst_sink_ready;
  assign rd_accept = avalonmm_read_slave_read & ~avalonmm_read_slave_waitrequest;
  assign pop       = rd_accept & ~avalonmm_read_slave_address;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    status_word                 = '0;
    status_word[ADDR_WIDTH:0]   = count_q;
    status_word[16]             = empty;
    status_word[17]             = full;
  end

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    readdata_d      = readdata_q;
    readdatavalid_d = rd_accept;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (rd_accept)
      readdata_d = avalonmm_read_slave_address ? status_word : mem[rd_ptr_q];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge rdclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge rdclock) begin
    if (push) mem[wr_ptr_q] <= avalonst_sink_data;
  end

  assign avalonmm_read_slave_readdata      = readdata_q;
  assign avalonmm_read_slave_readdatavalid = readdatavalid_q;
  assign fill_level                        = count_q;

endmodule

// File: tb/tb_reverb_template_s2m_fifo_ffta.sv
// Self-checking bench for the s2m FIFO: directed scenarios plus a random phase,
// all compared against a queue-based FIFO model of the stream/MM behaviour.
module tb_reverb_template_s2m_fifo_ffta;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          rdclock;
  logic          reset_n;
  logic [DW-1:0] sink_data;
  logic          sink_valid;
  logic          sink_ready;
  logic          mm_address;
  logic          mm_read;
  logic          mm_waitrequest;
  logic [DW-1:0] mm_readdata;
  logic          mm_readdatavalid;
  logic [AW:0]   fill_level;

  reverb_template_s2m_fifo_ffta #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .rdclock                          (rdclock),
    .reset_n                          (reset_n),
    .avalonst_sink_data               (sink_data),
    .avalonst_sink_valid              (sink_valid),
    .avalonst_sink_ready              (sink_ready),
    .avalonmm_read_slave_address      (mm_address),
    .avalonmm_read_slave_read         (mm_read),
    .avalonmm_read_slave_waitrequest  (mm_waitrequest),
    .avalonmm_read_slave_readdata     (mm_readdata),
    .avalonmm_read_slave_readdatavalid(mm_readdatavalid),
    .fill_level                       (fill_level)
  );

  initial rdclock = 1'b0;
  always #5 rdclock = ~rdclock;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_q[$];
  logic [31:0] last_rdata  = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = model_q.size();
    return 32'(n) | ((n == 0) ? 32'h0001_0000 : 32'h0) | ((n == DEPTH) ? 32'h0002_0000 : 32'h0);
  endfunction

  // One clock cycle of stimulus. Called 1 time unit after a rising edge; checks
  // the combinational handshakes before the edge and the registered results after.
  task automatic cycle(input bit push, input logic [31:0] d, input bit rd,
                       input bit addr, input string tag);
    bit          full, empty, acc_rd;
    logic [31:0] exp_data;
    sink_valid = push;
    sink_data  = d;
    mm_read    = rd;
    mm_address = addr;
    #1;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    check({tag, " ready"}, 32'(sink_ready), 32'(!full));
    check({tag, " waitrequest"}, 32'(mm_waitrequest), 32'(rd && !addr && empty));
    acc_rd   = rd && !(!addr && empty);
    exp_data = 32'h0;
    if (acc_rd) exp_data = addr ? model_status() : model_q.pop_front();
    if (push && !full) model_q.push_back(d);
    if (acc_rd) last_rdata = exp_data;
    @(posedge rdclock);
    #1;
    sink_valid = 1'b0;
    mm_read    = 1'b0;
    check({tag, " readdatavalid"}, 32'(mm_readdatavalid), 32'(acc_rd));
    check({tag, " readdata"}, mm_readdata, last_rdata);
    check({tag, " fill_level"}, 32'(fill_level), 32'(model_q.size()));
  endtask

  initial begin
    reset_n    = 1'b0;
    sink_data  = '0;
    sink_valid = 1'b0;
    mm_address = 1'b0;
    mm_read    = 1'b0;

    // 1. Reset: handshakes forced while reset is held, even with requests present.
    repeat (3) @(posedge rdclock);
    #1;
    sink_valid = 1'b1;
    mm_read    = 1'b1;
    #1;
    check("rst ready", 32'(sink_ready), 32'd0);
    check("rst waitrequest", 32'(mm_waitrequest), 32'd1);
    check("rst readdatavalid", 32'(mm_readdatavalid), 32'd0);
    check("rst fill_level", 32'(fill_level), 32'd0);
    check("rst readdata", mm_readdata, 32'd0);
    @(posedge rdclock);
    #1;
    check("rst rdv held", 32'(mm_readdatavalid), 32'd0);
    sink_valid = 1'b0;
    mm_read    = 1'b0;
    reset_n    = 1'b1;
    @(posedge rdclock);
    #1;
    check("post-rst ready", 32'(sink_ready), 32'd1);
    cycle(0, 0, 1, 1, "post-rst status");
    check("post-rst status word", mm_readdata, 32'h0001_0000);

    // 2. Ordering with back-to-back pops.
    cycle(1, 32'hA1, 0, 0, "ord push");
    cycle(1, 32'hA2, 0, 0, "ord push");
    cycle(1, 32'hA3, 0, 0, "ord push");
    cycle(0, 0, 1, 1, "ord status");
    check("ord status word", mm_readdata, 32'h0000_0003);
    cycle(0, 0, 1, 0, "ord pop");
    check("ord pop A1", mm_readdata, 32'hA1);
    cycle(0, 0, 1, 0, "ord pop");
    check("ord pop A2", mm_readdata, 32'hA2);
    cycle(0, 0, 1, 0, "ord pop");
    check("ord pop A3", mm_readdata, 32'hA3);

    // 3. Fill to capacity, pop at full while pushing, then drain across the wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'(i), 0, 0, "full push");
    check("full ready low", 32'(sink_ready), 32'd0);
    cycle(0, 0, 1, 1, "full status");
    check("full status word", mm_readdata, 32'h0002_0040);
    cycle(1, 32'd64, 1, 0, "full pop+push");
    check("full pop word", mm_readdata, 32'd0);
    cycle(1, 32'd64, 0, 0, "full refill");
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(0, 0, 1, 0, "wrap drain");
      check("wrap drain order", mm_readdata, 32'(i));
    end

    // 4. Empty stall: the master is held until a word arrives.
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, "stall");
    cycle(1, 32'hDEAD_BEEF, 1, 0, "stall push");
    cycle(0, 0, 1, 0, "stall release");
    check("stall word", mm_readdata, 32'hDEAD_BEEF);

    // 5. Concurrent push and pop hold occupancy constant.
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0, "conc prefill");
    for (int i = 0; i < 20; i++) cycle(1, $urandom, 1, 0, "conc");
    check("conc fill", 32'(fill_level), 32'd5);

    // 6. Reset mid-operation with a read just accepted and another pending.
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0, "mid prefill");
    cycle(0, 0, 1, 0, "mid pop");
    mm_read    = 1'b1;
    mm_address = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("mid rdv cleared", 32'(mm_readdatavalid), 32'd0);
    check("mid fill cleared", 32'(fill_level), 32'd0);
    check("mid readdata cleared", mm_readdata, 32'd0);
    check("mid waitrequest", 32'(mm_waitrequest), 32'd1);
    model_q.delete();
    last_rdata = 32'h0;
    @(posedge rdclock);
    #1;
    check("mid rdv after edge", 32'(mm_readdatavalid), 32'd0);
    mm_read = 1'b0;
    reset_n = 1'b1;
    @(posedge rdclock);
    #1;
    cycle(0, 0, 1, 1, "mid status");
    check("mid status word", mm_readdata, 32'h0001_0000);
    cycle(0, 0, 1, 0, "mid empty read");

    // Random mix of pushes, pops and status reads.
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), $urandom,
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 5) == 0), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
